// File: rtl/fourbit_sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module   : fourbit_sequential_divider
//  Purpose  : Unsigned restoring divider producing one quotient bit per cycle
//             behind a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module fourbit_sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_zero = '0;
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   w_trial;
  logic [WIDTH+1:0] w_diff;
  logic             w_borrow;
  logic             w_unused_r_msb;

  // Trial subtract is one bit wider than the trial value so its MSB is the borrow.
  assign w_trial        = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign w_diff         = {1'b0, w_trial} - {2'b00, dvsr_q};
  assign w_borrow       = w_diff[WIDTH+1];
  assign w_unused_r_msb = r_q[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          state_d = (divisor == '0) ? c_st_done : c_st_calc;
        end
      end
      c_st_calc: begin
        if (cnt_q == c_cnt_zero) begin
          state_d = c_st_done;
        end
      end
      c_st_done: state_d = c_st_idle;
      default:   state_d = c_st_idle;
    endcase
  end

  always_comb begin
    q_d    = q_q;
    dvsr_d = dvsr_q;
    r_d    = r_q;
    cnt_d  = cnt_q;
    zero_d = zero_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    case (state_q)
      c_st_idle: begin
        if (start) begin
          dvsr_d = divisor;
          q_d    = dividend;
          r_d    = '0;
          cnt_d  = c_cnt_init;
          zero_d = (divisor == '0);
        end
      end
      c_st_calc: begin
        r_d   = w_borrow ? w_trial : w_diff[WIDTH:0];
        q_d   = {q_q[WIDTH-2:0], ~w_borrow};
        cnt_d = cnt_q - c_cnt_one;
      end
      c_st_done: begin
        done_d = 1'b1;
        if (zero_q) begin
          quot_d = '1;
          rem_d  = q_q;
          dz_d   = 1'b1;
        end else begin
          quot_d = q_q;
          rem_d  = r_q[WIDTH-1:0];
          dz_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= '0;
      dvsr_q <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      zero_q <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dz_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      dvsr_q <= dvsr_d;
      r_q    <= r_d;
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dz_q   <= dz_d;
      done_q <= done_d;
    end
  end

  // busy stays up through the done pulse, which is driven while the FSM is back in IDLE.
  assign busy        = (state_q != c_st_idle) | done_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;

endmodule
`default_nettype wire
